// File: rtl/sseg_decoder.sv
// sseg_decoder: hex nibble to seven-segment pattern (bit0=a .. bit6=g).
// REG selects a registered (clk_en-gated) or purely combinational output;
// INV selects active-low (1) or active-high (0) segment drive.
// Optional feature macro: SSEG_BLANK_EN adds a 'blank' input that turns
// all segments off, sampled alongside num.
module sseg_decoder #(
    parameter int REG = 1,
    parameter int INV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [3:0] num,
`ifdef SSEG_BLANK_EN
    input  logic       blank,
`endif
    output logic [6:0] sseg
);

    logic [6:0] seg_raw;
    logic [6:0] seg_dec;
    logic [6:0] sseg_d;
    logic [6:0] sseg_q;
    logic [6:0] seg_pat;

    // Active-high decode of the hex digit (A, C, E, F upper case; b, d lower case)
    always_comb begin
        seg_raw = '0;
        case (num)
            4'h0: seg_raw = 7'h3F;
            4'h1: seg_raw = 7'h06;
            4'h2: seg_raw = 7'h5B;
            4'h3: seg_raw = 7'h4F;
            4'h4: seg_raw = 7'h66;
            4'h5: seg_raw = 7'h6D;
            4'h6: seg_raw = 7'h7D;
            4'h7: seg_raw = 7'h07;
            4'h8: seg_raw = 7'h7F;
            4'h9: seg_raw = 7'h6F;
            4'hA: seg_raw = 7'h77;
            4'hB: seg_raw = 7'h7C;
            4'hC: seg_raw = 7'h39;
            4'hD: seg_raw = 7'h5E;
            4'hE: seg_raw = 7'h79;
            4'hF: seg_raw = 7'h71;
            default: seg_raw = '0;
        endcase
    end

    // Optional blanking forces all segments off before the register
    always_comb begin
        seg_dec = seg_raw;
`ifdef SSEG_BLANK_EN
        if (blank) begin
            seg_dec = '0;
        end
`endif
    end

    // Register load is gated by the clock enable; otherwise hold
    always_comb begin
        sseg_d = clk_en ? seg_dec : sseg_q;
    end

    // Active-high pattern register, cleared (all segments off) by async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sseg_q <= '0;
        end else begin
            sseg_q <= sseg_d;
        end
    end

    // Select registered or combinational pattern, then apply output polarity.
    // The register is always present; with REG=0 it is simply unobserved.
    always_comb begin
        seg_pat = (REG != 0) ? sseg_q : seg_dec;
        sseg    = (INV != 0) ? ~seg_pat : seg_pat;
    end

endmodule

// File: tb/tb_sseg_decoder.sv
// Testbench for sseg_decoder: a registered active-low instance and a
// combinational active-high instance share the stimulus; expected values
// are queued when stimulus is driven and popped at each comparison.
module tb_sseg_decoder;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic [3:0] num;
    logic [6:0] sseg_r;
    logic [6:0] sseg_c;
`ifdef SSEG_BLANK_EN
    logic       blank;
`endif

    int total;
    int bad;

    logic [6:0] sbq[$];
    logic [6:0] tbl[16];

    sseg_decoder #(.REG(1), .INV(1)) u_r (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .num    (num),
`ifdef SSEG_BLANK_EN
        .blank  (blank),
`endif
        .sseg   (sseg_r)
    );

    sseg_decoder #(.REG(0), .INV(0)) u_c (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .num    (num),
`ifdef SSEG_BLANK_EN
        .blank  (blank),
`endif
        .sseg   (sseg_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [6:0] v);
        sbq.push_back(v);
    endtask

    task automatic check(input string tag, input logic [6:0] obs);
        logic [6:0] e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        clk_en = 1'b0;
        num    = 4'h0;
`ifdef SSEG_BLANK_EN
        blank  = 1'b0;
`endif

        // Reset with num=8, clk_en=1: output blank immediately and through edges
        #2;
        num    = 4'h8;
        clk_en = 1'b1;
        rst    = 1'b1;
        #1;
        push(7'h7F); check("rst_immediate", sseg_r);
        push(7'h7F); check("comb_in_rst_8", sseg_c);
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            push(7'h7F); check("rst_hold", sseg_r);
        end

        // Release reset: first enabled edge loads 8 -> ~7F = 00
        @(negedge clk);
        rst = 1'b0;
        #1;
        push(7'h7F); check("rst_release_pre", sseg_r);
        edge_sample();
        push(7'h00); check("rst_release_load", sseg_r);

        // Sweep 0..F with one enabled edge each; value appears exactly one edge later
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            num = 4'(i);
            #1;
            push(~tbl[(i + 15) % 16 == 15 ? 8 : (i + 15) % 16]);
            check("sweep_pre_edge", sseg_r);
            push(tbl[i]); check("comb_sweep", sseg_c);
            edge_sample();
            push(~tbl[i]); check("sweep_post_edge", sseg_r);
        end

        // Explicit boundary values called out for the registered path
        @(negedge clk); num = 4'h0; edge_sample();
        push(7'h40); check("num0_is_40", sseg_r);
        @(negedge clk); num = 4'h1; edge_sample();
        push(7'h79); check("num1_is_79", sseg_r);
        @(negedge clk); num = 4'hF; edge_sample();
        push(7'h0E); check("numF_is_0E", sseg_r);

        // Enable gating: load 3, then hold for 10 clocks while num=A
        @(negedge clk); num = 4'h3; edge_sample();
        push(7'h30); check("gate_load3", sseg_r);
        @(negedge clk);
        clk_en = 1'b0;
        num    = 4'hA;
        for (int i = 0; i < 10; i++) begin
            edge_sample();
            push(7'h30); check("gate_hold", sseg_r);
        end
        @(negedge clk);
        clk_en = 1'b1;
        edge_sample();
        push(7'h08); check("gate_release_A", sseg_r);

        // Combinational instance with reset held high: table values, register stays clear
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            num = 4'(i);
            #1;
            push(tbl[i]); check("comb_rst_sweep", sseg_c);
        end
        num = 4'h6; #1;
        push(7'h7D); check("comb_num6", sseg_c);
        num = 4'hD; #1;
        push(7'h5E); check("comb_numd", sseg_c);
        edge_sample();
        push(7'h7F); check("reg_cleared_in_rst", sseg_r);

        // Mid-operation reset between edges while showing 2
        @(negedge clk);
        rst = 1'b0;
        num = 4'h2;
        edge_sample();
        push(7'h24); check("mid_show2", sseg_r);
        #2;
        rst = 1'b1;
        #1;
        push(7'h7F); check("mid_rst_async", sseg_r);
        edge_sample();
        push(7'h7F); check("mid_rst_edge", sseg_r);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        push(7'h24); check("mid_rst_reload", sseg_r);

`ifdef SSEG_BLANK_EN
        // Blanking: sampled with num under clk_en; combinational on REG=0
        @(negedge clk);
        num   = 4'h5;
        blank = 1'b1;
        #1;
        push(7'h00); check("blank_comb", sseg_c);
        push(~tbl[2]); check("blank_pre_edge", sseg_r);
        edge_sample();
        push(7'h7F); check("blank_on", sseg_r);
        @(negedge clk);
        blank = 1'b0;
        #1;
        push(7'h7F); check("blank_off_pre_edge", sseg_r);
        edge_sample();
        push(7'h12); check("blank_off_5", sseg_r);
`endif

        if (sbq.size() != 0) begin
            bad++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog keeps the run bounded even if the sequence stalls
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
